// File: rtl/stdp_update_ctrl.sv
// Pair-based STDP sequencer for one synapse: times pre/post spike intervals and
// applies a decayed LTP/LTD step to the weight. Define STDP_STATS_EN for update counters.
module stdp_update_ctrl #(
  parameter int W_WIDTH   = 8,
  parameter int T_WIDTH   = 4,
  parameter int WINDOW    = 15,
  parameter int W_INIT    = 64,
  parameter int W_MAX     = 255,
  parameter int A_PLUS    = 16,
  parameter int A_MINUS   = 12,
  parameter int TAU_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pre_spike,
  input  logic               post_spike,
  input  logic               learn_en,
  input  logic               weight_load,
  input  logic [W_WIDTH-1:0] weight_in,
  output logic [W_WIDTH-1:0] weight,
  output logic               update_valid,
  output logic               update_ltp,
  output logic [T_WIDTH-1:0] dt_out,
  output logic [1:0]         state_o,
  output logic [7:0]         ltp_count,
  output logic [7:0]         ltd_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, PRE_ARMED = 2'd1, POST_ARMED = 2'd2, APPLY = 2'd3} state_t;

  localparam logic [W_WIDTH-1:0] AP       = W_WIDTH'(A_PLUS);
  localparam logic [W_WIDTH-1:0] AM       = W_WIDTH'(A_MINUS);
  localparam logic [W_WIDTH:0]   WMAX_EXT = (W_WIDTH+1)'(W_MAX);
  localparam logic [T_WIDTH-1:0] T_ONE    = T_WIDTH'(1);
  localparam logic [T_WIDTH-1:0] T_WIN    = T_WIDTH'(WINDOW);

  state_t             state, state_n;
  logic [T_WIDTH-1:0] timer, timer_n, dt_pend, dt_pend_n;
  logic               ltp_pend, ltp_pend_n, do_apply;

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    dt_pend_n  = dt_pend;
    ltp_pend_n = ltp_pend;
    do_apply   = 1'b0;
    if (!learn_en) begin
      state_n = IDLE;
      timer_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (pre_spike && !post_spike) begin
            state_n = PRE_ARMED;
            timer_n = T_ONE;
          end else if (post_spike && !pre_spike) begin
            state_n = POST_ARMED;
            timer_n = T_ONE;
          end
        end
        PRE_ARMED: begin
          // a coincident pre is dropped: the completing post takes precedence
          if (post_spike) begin
            state_n    = APPLY;
            dt_pend_n  = timer;
            ltp_pend_n = 1'b1;
          end else if (pre_spike) begin
            timer_n = T_ONE;
          end else if (timer == T_WIN) begin
            state_n = IDLE;
            timer_n = '0;
          end else begin
            timer_n = timer + T_ONE;
          end
        end
        POST_ARMED: begin
          if (pre_spike) begin
            state_n    = APPLY;
            dt_pend_n  = timer;
            ltp_pend_n = 1'b0;
          end else if (post_spike) begin
            timer_n = T_ONE;
          end else if (timer == T_WIN) begin
            state_n = IDLE;
            timer_n = '0;
          end else begin
            timer_n = timer + T_ONE;
          end
        end
        default: begin
          state_n  = IDLE;
          timer_n  = '0;
          do_apply = 1'b1;
        end
      endcase
    end
  end

  // step decays by halving every 2^TAU_SHIFT cycles of interval
  logic [T_WIDTH-1:0] dt_m1;
  logic [31:0]        shamt;
  logic [W_WIDTH-1:0] a_sel, dw, w_new;
  logic [W_WIDTH:0]   w_add, w_sub;

  always_comb begin
    dt_m1 = dt_pend - T_ONE;
    shamt = 32'(dt_m1) >> TAU_SHIFT;
    a_sel = ltp_pend ? AP : AM;
    dw    = (shamt >= 32'(W_WIDTH)) ? '0 : (a_sel >> shamt);
    w_add = {1'b0, weight} + {1'b0, dw};
    w_sub = {1'b0, weight} - {1'b0, dw};
    if (ltp_pend) w_new = (w_add > WMAX_EXT) ? WMAX_EXT[W_WIDTH-1:0] : w_add[W_WIDTH-1:0];
    else          w_new = w_sub[W_WIDTH] ? '0 : w_sub[W_WIDTH-1:0];
  end

  logic applied;
  assign applied = do_apply && !weight_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      dt_pend      <= '0;
      ltp_pend     <= 1'b0;
      weight       <= W_WIDTH'(W_INIT);
      update_valid <= 1'b0;
      update_ltp   <= 1'b0;
      dt_out       <= '0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      dt_pend      <= dt_pend_n;
      ltp_pend     <= ltp_pend_n;
      update_valid <= applied;
      if (weight_load) begin
        weight <= weight_in;
      end else if (do_apply) begin
        weight     <= w_new;
        update_ltp <= ltp_pend;
        dt_out     <= dt_pend;
      end
    end
  end

  assign state_o = state;

`ifdef STDP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ltp_count <= '0;
      ltd_count <= '0;
    end else if (applied) begin
      if (ltp_pend && ltp_count != 8'hFF)       ltp_count <= ltp_count + 8'd1;
      else if (!ltp_pend && ltd_count != 8'hFF) ltd_count <= ltd_count + 8'd1;
    end
  end
`else
  assign ltp_count = 8'd0;
  assign ltd_count = 8'd0;
`endif

endmodule

// File: tb/tb_stdp_update_ctrl.sv
// Directed bench for stdp_update_ctrl with default parameters.
module tb_stdp_update_ctrl;
  logic       clk = 1'b0;
  logic       rst, pre_spike, post_spike, learn_en, weight_load;
  logic [7:0] weight_in, weight, ltp_count, ltd_count;
  logic       update_valid, update_ltp;
  logic [3:0] dt_out;
  logic [1:0] state_o;
  int         passed = 0, total = 0;

  stdp_update_ctrl dut (
    .clk(clk), .rst(rst), .pre_spike(pre_spike), .post_spike(post_spike),
    .learn_en(learn_en), .weight_load(weight_load), .weight_in(weight_in),
    .weight(weight), .update_valid(update_valid), .update_ltp(update_ltp),
    .dt_out(dt_out), .state_o(state_o), .ltp_count(ltp_count), .ltd_count(ltd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // one clock with the given spikes; outputs settle 1ns after the edge
  task automatic cyc(input logic p, input logic q);
    pre_spike  = p;
    post_spike = q;
    @(posedge clk);
    #1;
    pre_spike  = 1'b0;
    post_spike = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; pre_spike = 1'b0; post_spike = 1'b0;
    learn_en = 1'b1; weight_load = 1'b0; weight_in = '0;
    idle(2);
    chk("rst_weight", weight, 64);
    chk("rst_uv", update_valid, 0);
    chk("rst_state", state_o, 0);
    chk("rst_dt", dt_out, 0);
    chk("rst_ltp", update_ltp, 0);
    rst = 1'b0;

    // LTP dt=2 -> +16
    cyc(1, 0);
    chk("ltp_armed", state_o, 1);
    idle(1);
    cyc(0, 1);
    chk("ltp_apply_state", state_o, 3);
    chk("ltp_hold", weight, 64);
    idle(1);
    chk("ltp_weight", weight, 80);
    chk("ltp_uv", update_valid, 1);
    chk("ltp_dir", update_ltp, 1);
    chk("ltp_dt", dt_out, 2);
    chk("ltp_idle", state_o, 0);
    idle(1);
    chk("ltp_uv_pulse", update_valid, 0);

    // LTD dt=5 -> -3
    cyc(0, 1);
    chk("ltd_armed", state_o, 2);
    idle(4);
    cyc(1, 0);
    idle(1);
    chk("ltd_weight", weight, 77);
    chk("ltd_dir", update_ltp, 0);
    chk("ltd_dt", dt_out, 5);
    chk("ltd_uv", update_valid, 1);

    // expiry after WINDOW cycles
    idle(1);
    cyc(1, 0);
    idle(14);
    chk("exp_still_armed", state_o, 1);
    idle(1);
    chk("exp_idle", state_o, 0);
    chk("exp_uv", update_valid, 0);
    idle(5);
    chk("exp_weight", weight, 77);

    // dt=WINDOW still pairs, but step decays to 0
    cyc(1, 0);
    idle(14);
    cyc(0, 1);
    chk("win_apply", state_o, 3);
    idle(1);
    chk("win_uv", update_valid, 1);
    chk("win_dt", dt_out, 15);
    chk("win_weight", weight, 77);

    // simultaneous spikes from IDLE
    cyc(1, 1);
    chk("simul_state", state_o, 0);
    idle(2);
    chk("simul_uv", update_valid, 0);
    chk("simul_weight", weight, 77);

    // load then saturate at W_MAX
    weight_load = 1'b1; weight_in = 8'd250;
    idle(1);
    weight_load = 1'b0;
    chk("load_weight", weight, 250);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0);
      cyc(0, 1);
      idle(1);
      chk("sat_weight", weight, 255);
    end
    chk("sat_uv", update_valid, 1);
    chk("sat_dt", dt_out, 1);

    // nearest-neighbour re-arm: second pre restarts the interval
    weight_load = 1'b1; weight_in = 8'd100;
    idle(1);
    weight_load = 1'b0;
    cyc(1, 0);
    idle(1);
    cyc(1, 0);
    cyc(0, 1);
    idle(1);
    chk("rearm_dt", dt_out, 1);
    chk("rearm_weight", weight, 116);

    // load coinciding with APPLY wins
    cyc(1, 0);
    cyc(0, 1);
    chk("ldapp_state", state_o, 3);
    weight_load = 1'b1; weight_in = 8'd33;
    idle(1);
    weight_load = 1'b0;
    chk("ldapp_weight", weight, 33);
    chk("ldapp_uv", update_valid, 0);
    chk("ldapp_state_idle", state_o, 0);

    // learn_en low cancels an armed interval
    cyc(1, 0);
    idle(1);
    learn_en = 1'b0;
    cyc(0, 1);
    chk("len_state", state_o, 0);
    idle(2);
    chk("len_uv", update_valid, 0);
    chk("len_weight", weight, 33);
    learn_en = 1'b1;

    // pre+post together while PRE_ARMED completes LTP with current timer
    cyc(1, 0);
    idle(1);
    cyc(1, 1);
    chk("pp_state", state_o, 3);
    idle(1);
    chk("pp_weight", weight, 49);
    chk("pp_dt", dt_out, 2);
    chk("pp_dir", update_ltp, 1);

`ifdef STDP_STATS_EN
    chk("ltp_count", ltp_count, 7);
    chk("ltd_count", ltd_count, 1);
`else
    chk("ltp_count_tied", ltp_count, 0);
    chk("ltd_count_tied", ltd_count, 0);
`endif

    // reset mid-operation
    cyc(1, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst2_state", state_o, 0);
    chk("rst2_weight", weight, 64);
    chk("rst2_dt", dt_out, 0);
    chk("rst2_ltp_count", ltp_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
